multicycle_seq: RTL

- Multi-cycle sequencer for the RV32I core datapath.
- Steps each instruction through fetch, decode, execute, memory and write-back.
- Drives PC/IR write enables and gates register-file and data-memory write strobes, so the combinational decoder's RegWrite/MemWrite only take effect in the correct cycle.
- Handshakes with instruction and data memory through req/ready, with a bounded wait and a sticky halt on fault.

---
 rtl/multicycle_seq_pkg.sv | 47 ++++
 rtl/multicycle_seq_wait_timer.sv | 34 +++
 rtl/multicycle_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/multicycle_seq_pkg.sv
// Shared encodings for the multi-cycle sequencer: states, opcodes,
// instruction classes, halt causes and write-data selects.
package multicycle_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_NONE  = 3'd0,
    CL_R     = 3'd1,
    CL_IALU  = 3'd2,
    CL_LOAD  = 3'd3,
    CL_STORE = 3'd4
  } cls_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_IMEM = 2'b01;
  localparam logic [1:0] ERR_ILL  = 2'b10;
  localparam logic [1:0] ERR_DMEM = 2'b11;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;

  function automatic cls_e classify(input logic [6:0] op);
    cls_e c;
    case (op)
      OP_R:     c = CL_R;
      OP_IALU:  c = CL_IALU;
      OP_LOAD:  c = CL_LOAD;
      OP_STORE: c = CL_STORE;
      default:  c = CL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_seq_wait_timer.sv
// Bounded-wait counter shared by the fetch and data-memory waits.
// expired_o flags the last allowed waiting cycle.
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle RV32I sequencer: fetch/decode/exec/mem/wb with
// bounded memory waits and a sticky halt on fault.
import multicycle_seq_pkg::*;

module multicycle_seq #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       ir_op,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             dmem_req,
  output logic             mem_write,
  output logic             alu_src_imm,
  output logic [1:0]       wd_src,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] instret_q;
  logic             tmr_clr, tmr_en, expired;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmr_clr),
    .en_i     (tmr_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    err_d       = err_q;
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    dmem_req    = 1'b0;
    mem_write   = 1'b0;
    alu_src_imm = 1'b0;
    wd_src      = WD_ALU;
    halted      = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = run;
        tmr_en   = run && !imem_ready;
        if (run && imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (run && expired) begin
          state_d = S_HALT;
          err_d   = ERR_IMEM;
        end
      end
      S_DECODE: begin
        cls_d = classify(ir_op);
        if (cls_d == CL_NONE) begin
          state_d = S_HALT;
          err_d   = ERR_ILL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_imm = (cls_q != CL_R);
        if (cls_q == CL_LOAD || cls_q == CL_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req    = 1'b1;
        alu_src_imm = 1'b1;
        mem_write   = (cls_q == CL_STORE);
        tmr_en      = !dmem_ready;
        if (dmem_ready) begin
          if (cls_q == CL_STORE) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (expired) begin
          state_d = S_HALT;
          err_d   = ERR_DMEM;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        wd_src    = (cls_q == CL_LOAD) ? WD_MEM : WD_ALU;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
    // A reset cycle abandons the in-flight instruction entirely.
    if (rst) begin
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      dmem_req  = 1'b0;
      mem_write = 1'b0;
    end
    tmr_clr = (state_d != state_q) || (state_q == S_FETCH && !run);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= CL_NONE;
      err_q     <= ERR_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
      if (pc_write) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign state   = state_q;
  assign err     = err_q;
  assign instret = instret_q;

endmodule
